nand_op_sequencer: RTL and testbench

- Sequences one NAND operation as an ordered stream of command, address and data beats.
- Sits between the host register block and the flash `fsm`, and is the only driver of the `fsm` controller-side byte interface.
- Accepts one operation at a time (READ_PAGE, PROGRAM_PAGE, BLOCK_ERASE, READ_STATUS).
- Waits on flash ready/busy with an optional timeout, then reports completion to the host.

---
 rtl/nand_op_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_nand_op_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_op_sequencer.sv
// ============================================================================
//  Module   : nand_op_sequencer
//  Purpose  : Turns one host NAND operation into an ordered CMD/ADDR/DATA beat
//             stream for the flash fsm, then waits on ready/busy.
//  Options  : SEQ_RB_TIMEOUT_EN enables the busy-wait timeout and H_Err.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nand_op_sequencer #(
  parameter int ADDR_CYCLES = 5,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                     P_clk,
  input  logic                     P_rst,
  input  logic                     H_Req,
  input  logic [1:0]               H_Op,
  input  logic [8*ADDR_CYCLES-1:0] H_Addr,
  input  logic [7:0]               H_Len,
  output logic                     H_Ack,
  output logic                     H_Done,
  output logic                     H_Err,
  output logic                     H_Busy,
  output logic                     C_Valid,
  output logic [1:0]               C_Kind,
  output logic [7:0]               C_Byte,
  input  logic                     C_Ack,
  input  logic [7:0]               W_Data,
  output logic                     W_Pop,
  input  logic                     F_nRB
);

  localparam logic [1:0] c_OP_READ   = 2'b00;
  localparam logic [1:0] c_OP_PROG   = 2'b01;
  localparam logic [1:0] c_OP_ERASE  = 2'b10;
  localparam logic [1:0] c_OP_STATUS = 2'b11;

  localparam logic [1:0] c_K_CMD  = 2'b00;
  localparam logic [1:0] c_K_ADDR = 2'b01;
  localparam logic [1:0] c_K_WR   = 2'b10;
  localparam logic [1:0] c_K_RD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD1    = 3'd1,
    S_ADDR    = 3'd2,
    S_DATA    = 3'd3,
    S_CMD2    = 3'd4,
    S_WAIT_RB = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  if (ADDR_CYCLES < 3 || TIMEOUT_W < 1) begin : g_param_check
    $error("nand_op_sequencer: ADDR_CYCLES must be >= 3 and TIMEOUT_W >= 1");
  end

  state_t                   state_q;
  logic [1:0]               op_q;
  logic [8*ADDR_CYCLES-1:0] addr_q;
  logic [8:0]               len_q;
  logic [8:0]               cnt_q;
  logic [1:0]               guard_q;
  logic                     rb_meta_q;
  logic                     rb_sync_q;
  logic                     valid_q;
  logic [1:0]               kind_q;
  logic [7:0]               byte_q;
  logic                     ack_q;
  logic                     done_q;
  logic                     busy_q;

  logic                     w_xfer;
  logic                     w_tmo_hit;
  logic [8:0]               w_first_cnt;
  logic [8:0]               w_first_idx;
  logic [8:0]               w_next_idx;
  logic [7:0]               w_addr_first;
  logic [7:0]               w_addr_next;

  function automatic logic [7:0] f_cmd1(input logic [1:0] op);
    case (op)
      c_OP_READ:  f_cmd1 = 8'h00;
      c_OP_PROG:  f_cmd1 = 8'h80;
      c_OP_ERASE: f_cmd1 = 8'h60;
      default:    f_cmd1 = 8'h70;
    endcase
  endfunction

  function automatic logic [7:0] f_cmd2(input logic [1:0] op);
    case (op)
      c_OP_READ: f_cmd2 = 8'h30;
      c_OP_PROG: f_cmd2 = 8'h10;
      default:   f_cmd2 = 8'hD0;
    endcase
  endfunction

  assign w_xfer = valid_q & C_Ack;

  // Address byte index is derived from the down-counter: idx = ADDR_CYCLES - cnt.
  // Erase loads 3 so it naturally starts at the top three bytes.
  assign w_first_cnt = (op_q == c_OP_ERASE) ? 9'd3 : 9'(ADDR_CYCLES);
  assign w_first_idx = 9'(ADDR_CYCLES) - w_first_cnt;
  assign w_next_idx  = 9'(ADDR_CYCLES) - cnt_q + 9'd1;

  always_comb begin
    w_addr_first = 8'h00;
    w_addr_next  = 8'h00;
    for (int i = 0; i < ADDR_CYCLES; i++) begin
      if (9'(i) == w_first_idx) w_addr_first = addr_q[8*i +: 8];
      if (9'(i) == w_next_idx)  w_addr_next  = addr_q[8*i +: 8];
    end
  end

`ifdef SEQ_RB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 err_q;
  assign w_tmo_hit = &tmo_q;
  assign H_Err     = err_q;
`else
  assign w_tmo_hit = 1'b0;
  assign H_Err     = 1'b0;
`endif

  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      addr_q    <= '0;
      len_q     <= 9'd0;
      cnt_q     <= 9'd0;
      guard_q   <= 2'd0;
      rb_meta_q <= 1'b1;
      rb_sync_q <= 1'b1;
      valid_q   <= 1'b0;
      kind_q    <= c_K_CMD;
      byte_q    <= 8'h00;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SEQ_RB_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      rb_meta_q <= F_nRB;
      rb_sync_q <= rb_meta_q;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_RB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (H_Req) begin
            op_q    <= H_Op;
            addr_q  <= H_Addr;
            len_q   <= (H_Len == 8'd0) ? 9'd256 : {1'b0, H_Len};
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_CMD1;
          end
        end
        S_CMD1: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            kind_q  <= c_K_CMD;
            byte_q  <= f_cmd1(op_q);
          end else if (w_xfer) begin
            if (op_q == c_OP_STATUS) begin
              state_q <= S_DATA;
              cnt_q   <= 9'd1;
              kind_q  <= c_K_RD;
              byte_q  <= 8'h00;
            end else begin
              state_q <= S_ADDR;
              cnt_q   <= w_first_cnt;
              kind_q  <= c_K_ADDR;
              byte_q  <= w_addr_first;
            end
          end
        end
        S_ADDR: begin
          if (w_xfer) begin
            if (cnt_q == 9'd1) begin
              if (op_q == c_OP_PROG) begin
                state_q <= S_DATA;
                cnt_q   <= len_q;
                kind_q  <= c_K_WR;
                byte_q  <= 8'h00;
              end else begin
                state_q <= S_CMD2;
                kind_q  <= c_K_CMD;
                byte_q  <= f_cmd2(op_q);
              end
            end else begin
              cnt_q  <= cnt_q - 9'd1;
              byte_q <= w_addr_next;
            end
          end
        end
        S_DATA: begin
          // Counter runs 256..1, so a 256-byte page never wraps through zero.
          if (w_xfer) begin
            if (cnt_q == 9'd1) begin
              if (op_q == c_OP_PROG) begin
                state_q <= S_CMD2;
                kind_q  <= c_K_CMD;
                byte_q  <= f_cmd2(op_q);
              end else begin
                state_q <= S_DONE;
                valid_q <= 1'b0;
                kind_q  <= c_K_CMD;
                byte_q  <= 8'h00;
                done_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 9'd1;
            end
          end
        end
        S_CMD2: begin
          if (w_xfer) begin
            state_q <= S_WAIT_RB;
            valid_q <= 1'b0;
            kind_q  <= c_K_CMD;
            byte_q  <= 8'h00;
            guard_q <= 2'd0;
`ifdef SEQ_RB_TIMEOUT_EN
            tmo_q   <= {{(TIMEOUT_W-1){1'b0}}, 1'b1};
`endif
          end
        end
        S_WAIT_RB: begin
`ifdef SEQ_RB_TIMEOUT_EN
          tmo_q <= tmo_q + 1'b1;
`endif
          if (w_tmo_hit) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
`ifdef SEQ_RB_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end else if (guard_q != 2'd3) begin
            guard_q <= guard_q + 2'd1;
          end else if (rb_sync_q) begin
            if (op_q == c_OP_READ) begin
              state_q <= S_DATA;
              cnt_q   <= len_q;
              valid_q <= 1'b1;
              kind_q  <= c_K_RD;
              byte_q  <= 8'h00;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign H_Ack   = ack_q;
  assign H_Done  = done_q;
  assign H_Busy  = busy_q;
  assign C_Valid = valid_q;
  assign C_Kind  = kind_q;
  assign C_Byte  = (kind_q == c_K_WR) ? W_Data : byte_q;
  assign W_Pop   = valid_q & C_Ack & (kind_q == c_K_WR);

endmodule

`default_nettype wire

// File: tb/tb_nand_op_sequencer.sv
// ============================================================================
//  Module   : tb_nand_op_sequencer
//  Purpose  : Directed self-checking bench for nand_op_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nand_op_sequencer;

`ifdef SEQ_RB_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 16;
`endif

  logic        P_clk = 1'b0;
  logic        P_rst = 1'b1;
  logic        H_Req = 1'b0;
  logic [1:0]  H_Op = 2'b00;
  logic [39:0] H_Addr = 40'h0;
  logic [7:0]  H_Len = 8'h00;
  logic        H_Ack, H_Done, H_Err, H_Busy, C_Valid, W_Pop;
  logic [1:0]  C_Kind;
  logic [7:0]  C_Byte;
  logic        C_Ack;
  logic [7:0]  W_Data;
  logic        F_nRB = 1'b1;

  logic        ack_mode = 1'b0;
  logic        pop_seen = 1'b0;
  logic [9:0]  beats[$];
  logic [9:0]  exp_q[$];
  int          pop_cnt = 0, done_cnt = 0, idle_cnt = 0, stall_viol = 0;
  logic        err_last = 1'b0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_beat = '0;
  int          n_total = 0, n_bad = 0;
  int          b_beats, b_pop, b_done, b_idle, b_stall;

  nand_op_sequencer #(.ADDR_CYCLES(5), .TIMEOUT_W(TW)) dut (
    .P_clk(P_clk), .P_rst(P_rst), .H_Req(H_Req), .H_Op(H_Op), .H_Addr(H_Addr),
    .H_Len(H_Len), .H_Ack(H_Ack), .H_Done(H_Done), .H_Err(H_Err), .H_Busy(H_Busy),
    .C_Valid(C_Valid), .C_Kind(C_Kind), .C_Byte(C_Byte), .C_Ack(C_Ack),
    .W_Data(W_Data), .W_Pop(W_Pop), .F_nRB(F_nRB)
  );

  always #5 P_clk = ~P_clk;

  // Host-side write FIFO model and C_Ack pattern, updated just after each edge.
  initial begin
    C_Ack  = 1'b1;
    W_Data = 8'h00;
    forever begin
      @(posedge P_clk);
      #1;
      if (pop_seen) W_Data = W_Data + 8'd1;
      C_Ack = ack_mode ? ~C_Ack : 1'b1;
    end
  end

  // Beat recorder: a beat with C_Valid & C_Ack at the falling edge transfers on the next rise.
  initial begin
    forever begin
      @(negedge P_clk);
      if (P_rst) begin
        pop_seen   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (C_Valid && C_Ack) beats.push_back({C_Kind, C_Byte});
        pop_seen = W_Pop;
        if (W_Pop) pop_cnt++;
        if (H_Done) begin
          done_cnt++;
          err_last = H_Err;
        end
        if (H_Busy && !C_Valid && beats.size() > b_beats) idle_cnt++;
        if (prev_stall && ({C_Valid, C_Kind, C_Byte} != prev_beat)) stall_viol++;
        prev_stall = C_Valid && !C_Ack;
        prev_beat  = {C_Valid, C_Kind, C_Byte};
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({H_Ack, H_Done, H_Err, H_Busy, C_Valid, C_Kind, C_Byte, W_Pop});
  endfunction

  task automatic mark();
    b_beats = beats.size();
    b_pop   = pop_cnt;
    b_done  = done_cnt;
    b_idle  = idle_cnt;
    b_stall = stall_viol;
    exp_q.delete();
  endtask

  task automatic req(input logic [1:0] op, input logic [39:0] addr, input logic [7:0] len);
    @(posedge P_clk); #1;
    H_Op = op; H_Addr = addr; H_Len = len; H_Req = 1'b1;
    @(negedge P_clk);
    check("ack_before_sample", 32'(H_Ack), 32'd0);
    @(negedge P_clk);
    check("ack_pulse", 32'(H_Ack), 32'd1);
    check("busy_at_ack", 32'(H_Busy), 32'd1);
    check("valid_at_ack", 32'(C_Valid), 32'd0);
    @(posedge P_clk); #1;
    H_Req = 1'b0;
    @(negedge P_clk);
    check("first_valid", 32'(C_Valid), 32'd1);
    check("ack_one_cycle", 32'(H_Ack), 32'd0);
  endtask

  task automatic wait_beats(input int n, input int limit);
    int k = 0;
    while ((beats.size() - b_beats) < n && k < limit) begin
      @(negedge P_clk); #2;
      k++;
    end
    check("wait_beats_bound", 32'((beats.size() - b_beats) >= n), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cnt == b_done && k < limit) begin
      @(negedge P_clk); #2;
      k++;
    end
    check("wait_done_bound", 32'(done_cnt != b_done), 32'd1);
  endtask

  task automatic cmp_beats(input string tag);
    logic [9:0] got;
    check({tag, "_count"}, 32'(beats.size() - b_beats), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (b_beats + i < beats.size()) ? beats[b_beats + i] : 10'h3FF;
      check($sformatf("%s_beat%0d", tag, i), 32'(got), 32'(exp_q[i]));
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] b);
    exp_q.push_back({k, b});
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge P_clk);
    @(negedge P_clk);
    check("reset_outputs", outs_vec(), 32'd0);
    @(posedge P_clk); #1;
    P_rst = 1'b0;

    // Reset during the second address beat of a READ_PAGE
    mark();
    req(2'b00, 40'hA4A3A2A1A0, 8'd4);
    wait_beats(3, 20);
    check("mid_kind_addr", 32'(C_Kind), 32'd1);
    check("mid_byte_a1", 32'(C_Byte), 32'hA1);
    P_rst = 1'b1;
    #1;
    check("mid_reset_outputs", outs_vec(), 32'd0);
    @(posedge P_clk); #1;
    P_rst = 1'b0;

    // READ_PAGE restarts from CMD 00h
    mark();
    F_nRB = 1'b0;
    req(2'b00, 40'hA4A3A2A1A0, 8'd4);
    wait_beats(7, 40);
    repeat (10) @(posedge P_clk);
    #1 F_nRB = 1'b1;
    wait_done(200);
    push(2'b00, 8'h00);
    for (int i = 0; i < 5; i++) push(2'b01, 8'hA0 + 8'(i));
    push(2'b00, 8'h30);
    for (int i = 0; i < 4; i++) push(2'b11, 8'h00);
    cmp_beats("rd");
    check("rd_err", 32'(err_last), 32'd0);
    check("rd_wait_gap_min", 32'((idle_cnt - b_idle) >= 11), 32'd1);
    @(negedge P_clk);
    check("rd_busy_cleared", 32'(H_Busy), 32'd0);
    repeat (3) @(negedge P_clk);
    #2 check("rd_done_once", 32'(done_cnt - b_done), 32'd1);

    // PROGRAM_PAGE, 256 bytes, C_Ack toggling
    mark();
    ack_mode = 1'b1;
    req(2'b01, 40'h0504030201, 8'd0);
    wait_done(3000);
    ack_mode = 1'b0;
    push(2'b00, 8'h80);
    for (int i = 1; i <= 5; i++) push(2'b01, 8'(i));
    for (int i = 0; i < 256; i++) push(2'b10, 8'(i));
    push(2'b00, 8'h10);
    cmp_beats("pg");
    check("pg_pops", 32'(pop_cnt - b_pop), 32'd256);
    check("pg_stall_stable", 32'(stall_viol - b_stall), 32'd0);
    check("pg_twb_guard", 32'((idle_cnt - b_idle) >= 5), 32'd1);
    check("pg_err", 32'(err_last), 32'd0);
    repeat (2) @(negedge P_clk);

    // BLOCK_ERASE uses address bytes 2..4
    mark();
    req(2'b10, 40'h5544332211, 8'd7);
    wait_done(200);
    push(2'b00, 8'h60);
    push(2'b01, 8'h33);
    push(2'b01, 8'h44);
    push(2'b01, 8'h55);
    push(2'b00, 8'hD0);
    cmp_beats("er");
    check("er_twb_guard", 32'((idle_cnt - b_idle) >= 5), 32'd1);
    check("er_err", 32'(err_last), 32'd0);
    repeat (2) @(negedge P_clk);

    // READ_STATUS ignores H_Len and never waits on ready/busy
    mark();
    req(2'b11, 40'h0, 8'd9);
    wait_done(50);
    push(2'b00, 8'h70);
    push(2'b11, 8'h00);
    cmp_beats("st");
    check("st_no_wait", 32'(idle_cnt - b_idle), 32'd1);
    repeat (3) @(negedge P_clk);
    #2 check("st_done_once", 32'(done_cnt - b_done), 32'd1);

`ifdef SEQ_RB_TIMEOUT_EN
    // Busy timeout: 15 WAIT_RB cycles, then H_Done with H_Err, no data beats
    mark();
    F_nRB = 1'b0;
    req(2'b00, 40'hA4A3A2A1A0, 8'd4);
    wait_done(200);
    check("to_err", 32'(err_last), 32'd1);
    check("to_wait_cycles", 32'(idle_cnt - b_idle), 32'd16);
    push(2'b00, 8'h00);
    for (int i = 0; i < 5; i++) push(2'b01, 8'hA0 + 8'(i));
    push(2'b00, 8'h30);
    cmp_beats("to");
    F_nRB = 1'b1;
    repeat (2) @(negedge P_clk);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
